usb_fs_tx_phy: RTL

USB full-speed (12 Mb/s) transmit line encoder for the DFU bootloader. It accepts packet bytes from the protocol engine over a valid/ready stream and emits the line signals the pin wrapper feeds to its tristate IO buffers: SYNC, NRZI encoding, bit stuffing and EOP. It is the transmit counterpart of the receive decoder behind the same pins.

---
 rtl/usb_fs_tx_phy_if.sv | 10 +
 rtl/usb_fs_tx_phy.sv | 133 +++++++++++++
 2 files changed

// File: rtl/usb_fs_tx_phy_if.sv
// usb_fs_tx_phy_if: byte stream from the protocol engine into the FS transmit encoder
// tx_data/tx_valid/tx_last flow master->slave, tx_ready pulses slave->master when a byte is consumed
interface usb_fs_tx_phy_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, tx_last, input tx_ready);
    modport slave (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/usb_fs_tx_phy.sv
// usb_fs_tx_phy: USB full-speed transmit line encoder (SYNC, NRZI, bit stuffing, EOP)
// clk_48mhz/reset: clock and synchronous active-high reset; tx: byte stream slave
// usb_p_tx/usb_n_tx/usb_tx_en: pin drive values and output enable
// tx_busy: packet in flight; tx_underflow: pulse when a mid-packet byte was missing
module usb_fs_tx_phy #(
    parameter int CLKS_PER_BIT = 4,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic            clk_48mhz,
    input  logic            reset,
    usb_fs_tx_phy_if.slave  tx,
    output logic            usb_p_tx,
    output logic            usb_n_tx,
    output logic            usb_tx_en,
    output logic            tx_busy,
    output logic            tx_underflow
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
    localparam int PW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] SE0_LAST = 4'(EOP_SE0_BITS - 1);
    state_t state, state_nx;
    logic [PW-1:0] phase;
    logic [2:0] bit_cnt, bit_nx, ones, ones_nx;
    logic [7:0] cur, cur_nx, hold, nxt_byte;
    logic [3:0] se0_cnt, se0_nx;
    logic last, last_nx, hold_last, have_hold, nxt_last, line_j, line_nx;
    logic strobe, win, accept, underflow, emit, bit_v, load, adv;
    assign strobe = phase == PH_LAST;
    // bit 7 of a non-last byte on the line with no follow-up byte held yet
    assign win = state == DATA && bit_cnt == 3'd7 && !last && !have_hold;
    assign tx.tx_ready = !reset && tx.tx_valid && (state == IDLE || win);
    assign accept = win && tx.tx_ready;
    assign underflow = win && strobe && !tx.tx_valid;
    // a byte accepted on the final cycle of bit 7 bypasses the hold register
    assign nxt_byte = have_hold ? hold : tx.tx_data;
    assign nxt_last = have_hold ? hold_last : tx.tx_last;
    assign usb_tx_en = state != IDLE;
    assign tx_busy = state != IDLE;
    assign usb_p_tx = state != EOP_SE0 && line_j;
    assign usb_n_tx = state != EOP_SE0 && !line_j;
    assign tx_underflow = underflow;
    always_comb begin
        state_nx = state;
        bit_nx = bit_cnt;
        cur_nx = cur;
        last_nx = last;
        se0_nx = se0_cnt;
        emit = 1'b0;
        bit_v = 1'b0;
        load = 1'b0;
        adv = 1'b0;
        if (state == IDLE) begin
            if (tx.tx_ready) begin
                state_nx = SYNC;
                bit_nx = 3'd0;
                cur_nx = tx.tx_data;
                last_nx = tx.tx_last;
                se0_nx = 4'd0;
                emit = 1'b1;
            end
        end else if (strobe) begin
            case (state)
                SYNC: begin
                    emit = 1'b1;
                    bit_v = bit_cnt == 3'd7 ? cur[0] : bit_cnt == 3'd6;
                    state_nx = bit_cnt == 3'd7 ? DATA : SYNC;
                    bit_nx = bit_cnt + 3'd1;
                end
                DATA: begin
                    if (underflow) state_nx = EOP_SE0;
                    else if (ones == 3'd6) begin
                        state_nx = STUFF;
                        emit = 1'b1;
                    end else adv = 1'b1;
                end
                STUFF: adv = 1'b1;
                EOP_SE0: begin
                    se0_nx = se0_cnt + 4'd1;
                    state_nx = se0_cnt == SE0_LAST ? EOP_J : EOP_SE0;
                end
                default: state_nx = IDLE;
            endcase
            if (adv) begin
                if (bit_cnt != 3'd7) begin
                    state_nx = DATA;
                    bit_nx = bit_cnt + 3'd1;
                    emit = 1'b1;
                    bit_v = cur[bit_cnt + 3'd1];
                end else if (last) state_nx = EOP_SE0;
                else begin
                    state_nx = DATA;
                    bit_nx = 3'd0;
                    load = 1'b1;
                    cur_nx = nxt_byte;
                    last_nx = nxt_last;
                    emit = 1'b1;
                    bit_v = nxt_byte[0];
                end
            end
        end
        // NRZI: a 0 bit toggles J/K, a 1 bit holds the line
        line_nx = emit ? (bit_v ? line_j : !line_j) : (state_nx == EOP_J ? 1'b1 : line_j);
        ones_nx = emit ? (bit_v ? ones + 3'd1 : 3'd0) : ones;
    end
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
            bit_cnt <= 3'd0;
            ones <= 3'd0;
            cur <= 8'd0;
            last <= 1'b0;
            hold <= 8'd0;
            hold_last <= 1'b0;
            have_hold <= 1'b0;
            line_j <= 1'b1;
            se0_cnt <= 4'd0;
        end else begin
            state <= state_nx;
            phase <= (state == IDLE || strobe) ? '0 : phase + PW'(1);
            bit_cnt <= bit_nx;
            ones <= ones_nx;
            cur <= cur_nx;
            last <= last_nx;
            line_j <= line_nx;
            se0_cnt <= se0_nx;
            hold <= accept ? tx.tx_data : hold;
            hold_last <= accept ? tx.tx_last : hold_last;
            have_hold <= load ? 1'b0 : (accept || have_hold);
        end
    end
endmodule
